imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the byte-addressed, big-endian instruction memory: receives a
//  program as a byte stream (valid/ready) and writes it byte-by-byte into the memory's
//  write port, starting at address 0. Holds the processor (cpu_hold) while loading.
//  Sits between the host/serial byte source and instruction memory; replaces $readmemb in hardware.
// PARAMETERS
//  ADDR_WIDTH  8    byte address width; memory depth = 2**ADDR_WIDTH bytes (256)
//  BYTE_WIDTH  8    width of stream and memory write data
// PORTS
//  clk          in   1   single clock, all logic rising-edge
//  reset        in   1   synchronous, active-high
//  start        in   1   pulse: begin a load (ignored unless IDLE or DONE)
//  byte_valid   in   1   stream byte present
//  byte_data    in   8   stream byte
//  byte_ready   out  1   loader accepts byte this cycle (transfer = valid & ready)
//  wr_en        out  1   memory byte write strobe
//  wr_addr      out  8   memory byte address
//  wr_data      out  8   memory byte data
//  cpu_hold     out  1   processor held (PC/fetch frozen) while 1
//  done         out  1   load complete; held until next start or reset
//  words_loaded out  7   32-bit words written in current/last load (0..64)
//  err          out  1   checksum failure (CHECKSUM_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE; byte_ready, wr_en, cpu_hold, done, err = 0; wr_addr, wr_data = 0;
//    words_loaded = 0. Reset mid-load aborts immediately; partial memory contents remain.
//  - FSM: IDLE -start-> HDR -byte-> DATA -last byte-> (CKS) -> DONE -start-> HDR.
//  - start in HDR/DATA/CKS ignored. start in IDLE/DONE clears done, err, words_loaded,
//    address counter; cpu_hold = 1 from next cycle.
//  - HDR: byte_ready=1; first accepted byte = word count N; N=0 means 64 words (full memory).
//  - DATA: byte_ready=1; each accepted byte written 1 cycle later: wr_en=1 for exactly one
//    cycle, wr_addr = byte index, wr_data = byte. Index starts 0, increments by 1 per byte.
//    Stream order = memory order, so byte 4k is MSB of word k (big-endian, matches fetch).
//  - words_loaded increments when byte index[1:0]==3 is accepted.
//  - Last data byte = index 4N-1; 8-bit index wraps 255->0 internally at N=64, never written.
//  - No accepted byte -> no wr_en; byte_valid gaps of any length allowed; byte_data ignored
//    when byte_valid=0 or byte_ready=0.
//  - DONE entered the cycle after final write strobe; done=1, cpu_hold=0, byte_ready=0.
//  - Outside HDR/DATA/CKS byte_ready=0; stray bytes dropped, never written.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the data bytes, one CKS byte is accepted;
//    XOR of header, all data and CKS bytes must equal 0x00; else err=1 in DONE (held until
//    next start/reset). Memory still written; cpu_hold released regardless.
//  Undefined: no CKS state; DONE follows last data byte; err constant 0.
// STRUCTURE
//  Shared package mips_pkg: loader state enum (IDLE, HDR, DATA, CKS, DONE), constant
//  IMEM_BYTES=256, IMEM_WORDS=64. Single module; no sub-module (index counter and XOR
//  accumulator are a few lines inline).
// TESTING
//  1. reset held 2 cycles -> all outputs 0, state IDLE, byte_ready=0.
//  2. start; bytes 02,20,08,00,05,AC,09,00,04 -> wr at addr 0..7 data 20..04, words_loaded=2,
//     done=1, cpu_hold=0 the cycle after addr 7 strobe.
//  3. same stream with byte_valid low 1-3 cycles between bytes -> identical writes, no extra wr_en.
//  4. header 00 then 256 bytes (i) -> 256 writes addr 0..255, words_loaded=64, no write to addr 0
//     after wrap, done=1.
//  5. reset after 3 data bytes -> outputs at reset values next cycle; new start rewrites from addr 0.
//  6. IMEM_LOADER_CHECKSUM_EN: stream 01,11,22,33,44,CKS=45 -> err=0; CKS=00 -> err=1, done=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory side of the core: loader states,
// memory geometry and the checksum fold used by the program loader.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CKS  = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

  localparam int IMEM_BYTES = 256;
  localparam int IMEM_WORDS = 64;

  function automatic logic [7:0] cks_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a program (header byte = word count, then big-endian bytes) into the
// instruction memory write port. Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [BYTE_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [6:0]            words_loaded,
  output logic                  err
);
  import mips_pkg::*;

  loader_state_t         state_r;
  logic                  byte_ready_r;
  logic                  wr_en_r;
  logic                  cpu_hold_r;
  logic                  done_r;
  logic                  last_r;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [ADDR_WIDTH-1:0] last_idx_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [BYTE_WIDTH-1:0] wr_data_r;
  logic [6:0]            words_r;
  logic                  xfer_s;

  assign xfer_s       = byte_valid & byte_ready_r;
  assign byte_ready   = byte_ready_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign words_loaded = words_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] xor_r;
  logic                  err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Loader FSM, write pipeline and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      byte_ready_r <= 1'b0;
      wr_en_r      <= 1'b0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
      last_r       <= 1'b0;
      idx_r        <= '0;
      last_idx_r   <= '0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      words_r      <= 7'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_r        <= '0;
      err_r        <= 1'b0;
`endif
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r      <= ST_HDR;
            byte_ready_r <= 1'b1;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            last_r       <= 1'b0;
            idx_r        <= '0;
            words_r      <= 7'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r        <= '0;
            err_r        <= 1'b0;
`endif
          end
        end
        ST_HDR: begin
          if (xfer_s) begin
            // Last index is 4N-1 truncated; header 0 wraps to the top of memory (64 words).
            last_idx_r <= ADDR_WIDTH'({byte_data, 2'b00} - (BYTE_WIDTH + 2)'(1));
            state_r    <= ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r      <= cks_fold(xor_r, byte_data);
`endif
          end
        end
        ST_DATA: begin
          if (last_r) begin
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
            last_r     <= 1'b0;
          end else if (xfer_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= idx_r;
            wr_data_r <= byte_data;
            idx_r     <= idx_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (idx_r[1:0] == 2'b11) begin
              words_r <= words_r + 7'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r <= cks_fold(xor_r, byte_data);
            if (idx_r == last_idx_r) begin
              state_r <= ST_CKS;
            end
`else
            if (idx_r == last_idx_r) begin
              byte_ready_r <= 1'b0;
              last_r       <= 1'b1;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CKS: begin
          if (xfer_s) begin
            state_r      <= ST_DONE;
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= (cks_fold(xor_r, byte_data) != 8'h00);
          end
        end
`endif
        default: begin
          state_r      <= ST_IDLE;
          byte_ready_r <= 1'b0;
          cpu_hold_r   <= 1'b0;
          last_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, randomized loads against a
// stream-level model, and reset-abort / checksum sequences.
module tb_imem_loader;

  localparam int PAT_T2  = 0;
  localparam int PAT_T6  = 1;
  localparam int PAT_INC = 2;
  localparam int PAT_RND = 3;

  typedef struct {
    logic [7:0] hdr;
    int         pat;
    int         gmin;
    int         gmax;
    int         start_at;
    logic [7:0] flip;
    int         exp_words;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready, wr_en, cpu_hold, done, err;
  logic [7:0] wr_addr, wr_data;
  logic [6:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  logic [15:0] wr_q[$];
  logic [7:0] t2[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
  logic [7:0] t6[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  vec_t tbl[6];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done),
    .words_loaded(words_loaded), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_q.push_back({wr_addr, wr_data});
      last_wr_cyc <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, byte_ready, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_addr"}, wr_addr, 8'h00);
    chk({tag, "_data"}, wr_data, 8'h00);
    chk({tag, "_hold"}, cpu_hold, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_words"}, words_loaded, 7'd0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  // Offers one byte until accepted; called at posedge+1, returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit with_start, output bit ok);
    bit acc;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) ok = 1'b1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_load(input vec_t v);
    logic [7:0] data[$];
    logic [7:0] strm[$];
    logic [7:0] x;
    int n, gap, dcyc;
    bit ok, got;
    n = 4 * ((v.hdr == 8'h00) ? 64 : int'(v.hdr));
    for (int i = 0; i < n; i++) begin
      case (v.pat)
        PAT_T2:  data.push_back(t2[i % 8]);
        PAT_T6:  data.push_back(t6[i % 4]);
        PAT_INC: data.push_back(i[7:0]);
        default: data.push_back(8'($urandom));
      endcase
    end
    strm.push_back(v.hdr);
    x = v.hdr;
    foreach (data[i]) begin
      strm.push_back(data[i]);
      x = x ^ data[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    strm.push_back(x ^ v.flip);
`endif
    wr_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_hold", cpu_hold, 1'b1);
    chk("start_ready", byte_ready, 1'b1);
    chk("start_done", done, 1'b0);
    chk("start_words", words_loaded, 7'd0);
    chk("start_err", err, 1'b0);
    @(posedge clk);
    #1;
    foreach (strm[k]) begin
      gap = (k == 0) ? 0 : $urandom_range(v.gmax, v.gmin);
      repeat (gap) begin
        byte_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      send_byte(strm[k], (k - 1) == v.start_at, ok);
      if (!ok) begin
        chk($sformatf("accept_timeout_%0d", k), 32'd0, 32'd1);
        break;
      end
    end
    got = 1'b0;
    dcyc = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    chk("done_seen", got, 1'b1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("done_timing", dcyc, last_wr_cyc + 1);
`endif
    @(posedge clk);
    #1;
    chk("n_writes", wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size()) chk($sformatf("wr_%0d", i), wr_q[i], {i[7:0], data[i]});
    end
    chk("words", words_loaded, v.exp_words);
    chk("hold_end", cpu_hold, 1'b0);
    chk("ready_end", byte_ready, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("err", err, v.flip != 8'h00);
`else
    chk("err", err, 1'b0);
`endif
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_writes", wr_q.size(), n);
    chk("done_held", done, 1'b1);
  endtask

  initial begin
    vec_t v;
    bit ok;
    tbl[0] = '{8'h02, PAT_T2,  0, 0, -1, 8'h00, 2};
    tbl[1] = '{8'h02, PAT_T2,  1, 3, -1, 8'h00, 2};
    tbl[2] = '{8'h00, PAT_INC, 0, 0, -1, 8'h00, 64};
    tbl[3] = '{8'h01, PAT_RND, 0, 2,  2, 8'h00, 1};
    tbl[4] = '{8'h05, PAT_RND, 1, 1, -1, 8'h00, 5};
    tbl[5] = '{8'h40, PAT_RND, 0, 1, -1, 8'h00, 64};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("idle");
    @(posedge clk);
    #1;

    foreach (tbl[i]) do_load(tbl[i]);

    for (int r = 0; r < 6; r++) begin
      v.hdr = 8'($urandom_range(12, 1));
      v.pat = PAT_RND;
      v.gmin = 0;
      v.gmax = 2;
      v.start_at = -1;
      v.flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      v.exp_words = int'(v.hdr);
      do_load(v);
    end

    // Abort after three data bytes, then a fresh load must start again at address 0.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h04, 1'b0, ok);
    for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k), 1'b0, ok);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    @(posedge clk);
    #1;
    do_load(tbl[0]);

`ifdef IMEM_LOADER_CHECKSUM_EN
    v = '{8'h01, PAT_T6, 0, 0, -1, 8'h00, 1};
    do_load(v);
    v.flip = 8'h45;
    do_load(v);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
